sprite_reg_bank: RTL and testbench

Parametrised, double-buffered register bank holding the rectangle, enable and colour of `NUM_SPRITES` sprites for the VGA renderer. It sits between the host command port (`write`/`command`/`data`) and the per-pixel sprite compare logic. Host writes land in per-sprite shadow registers. Shadow contents are copied into the active registers only at a frame boundary, or on an explicit commit command, so the renderer never shows a half-updated sprite.

---
 rtl/sprite_reg_pkg.sv | 32 +++
 rtl/sprite_slot.sv | 130 +++++++++++++
 rtl/sprite_reg_bank.sv | 91 +++++++++
 tb/tb_sprite_reg_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_reg_pkg.sv
// sprite_reg_pkg
//   Shared definitions for the sprite register bank: host command codes,
//   the reset rectangle and the reset colour, plus a small decode helper.
package sprite_reg_pkg;

    // Host command codes carried on the 4-bit command port.
    localparam logic [3:0] CMD_NONE   = 4'd0;
    localparam logic [3:0] CMD_ENABLE = 4'd1;
    localparam logic [3:0] CMD_X1     = 4'd2;
    localparam logic [3:0] CMD_Y1     = 4'd3;
    localparam logic [3:0] CMD_X2     = 4'd4;
    localparam logic [3:0] CMD_Y2     = 4'd5;
    localparam logic [3:0] CMD_COLOR  = 4'd6;
    localparam logic [3:0] CMD_MOVE_X = 4'd7;
    localparam logic [3:0] CMD_MOVE_Y = 4'd8;
    localparam logic [3:0] CMD_COMMIT = 4'd9;

    // Reset rectangle shared by every sprite slot.
    localparam int unsigned DEF_X1 = 32'd0;
    localparam int unsigned DEF_Y1 = 32'd0;
    localparam int unsigned DEF_X2 = 32'd100;
    localparam int unsigned DEF_Y2 = 32'd100;

    // Reset colour is all ones; slots truncate this to their colour width.
    localparam logic [31:0] DEF_COLOR = 32'hFFFF_FFFF;

    // True for the codes that modify shadow state (enable .. move-y).
    function automatic logic is_write_cmd(input logic [3:0] cmd);
        return (cmd >= CMD_ENABLE) && (cmd <= CMD_MOVE_Y);
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// sprite_slot
//   One sprite's shadow and active registers. Shadow state is updated by
//   host commands when wr_en is high; active state copies the whole shadow
//   when commit is high. Because both update on the same edge, a commit
//   always captures the shadow as it was before a same-cycle write.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en             accepted write command targets this slot
//   cmd, data         command code and operand
//   commit            copy shadow into active this cycle
//   en, x1, y1, x2, y2, color   active (registered) sprite state
module sprite_slot
    import sprite_reg_pkg::*;
#(
    parameter int   X_W        = 10,
    parameter int   Y_W        = 9,
    parameter int   COLOR_W    = 3,
    parameter int   DATA_W     = 10,
    parameter logic DEFAULT_EN = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [3:0]         cmd,
    input  logic [DATA_W-1:0]  data,
    input  logic               commit,
    output logic               en,
    output logic [X_W-1:0]     x1,
    output logic [Y_W-1:0]     y1,
    output logic [X_W-1:0]     x2,
    output logic [Y_W-1:0]     y2,
    output logic [COLOR_W-1:0] color
);

    logic               sh_en_r,  act_en_r,  nxt_en_s;
    logic [X_W-1:0]     sh_x1_r,  act_x1_r,  nxt_x1_s;
    logic [Y_W-1:0]     sh_y1_r,  act_y1_r,  nxt_y1_s;
    logic [X_W-1:0]     sh_x2_r,  act_x2_r,  nxt_x2_s;
    logic [Y_W-1:0]     sh_y2_r,  act_y2_r,  nxt_y2_s;
    logic [COLOR_W-1:0] sh_col_r, act_col_r, nxt_col_s;
    logic [X_W-1:0]     width_x_s;
    logic [Y_W-1:0]     width_y_s;
    logic [3:0]         eff_cmd_s;

    // Next shadow state: decode the command, moves keep the current width.
    always_comb begin
        nxt_en_s  = sh_en_r;
        nxt_x1_s  = sh_x1_r;
        nxt_y1_s  = sh_y1_r;
        nxt_x2_s  = sh_x2_r;
        nxt_y2_s  = sh_y2_r;
        nxt_col_s = sh_col_r;
        // Widths wrap modulo 2^W so moves also wrap instead of saturating.
        width_x_s = sh_x2_r - sh_x1_r;
        width_y_s = sh_y2_r - sh_y1_r;
        eff_cmd_s = wr_en ? cmd : CMD_NONE;
        case (eff_cmd_s)
            CMD_ENABLE: nxt_en_s  = data[0];
            CMD_X1:     nxt_x1_s  = data[X_W-1:0];
            CMD_Y1:     nxt_y1_s  = data[Y_W-1:0];
            CMD_X2:     nxt_x2_s  = data[X_W-1:0];
            CMD_Y2:     nxt_y2_s  = data[Y_W-1:0];
            CMD_COLOR:  nxt_col_s = data[COLOR_W-1:0];
            CMD_MOVE_X: begin
                nxt_x1_s = data[X_W-1:0];
                nxt_x2_s = data[X_W-1:0] + width_x_s;
            end
            CMD_MOVE_Y: begin
                nxt_y1_s = data[Y_W-1:0];
                nxt_y2_s = data[Y_W-1:0] + width_y_s;
            end
            default: begin
                nxt_en_s = sh_en_r;
            end
        endcase
    end

    // Shadow registers: follow the decoded next state every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_en_r  <= DEFAULT_EN;
            sh_x1_r  <= X_W'(DEF_X1);
            sh_y1_r  <= Y_W'(DEF_Y1);
            sh_x2_r  <= X_W'(DEF_X2);
            sh_y2_r  <= Y_W'(DEF_Y2);
            sh_col_r <= COLOR_W'(DEF_COLOR);
        end else begin
            sh_en_r  <= nxt_en_s;
            sh_x1_r  <= nxt_x1_s;
            sh_y1_r  <= nxt_y1_s;
            sh_x2_r  <= nxt_x2_s;
            sh_y2_r  <= nxt_y2_s;
            sh_col_r <= nxt_col_s;
        end
    end

    // Active registers: take the pre-write shadow on commit, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_en_r  <= DEFAULT_EN;
            act_x1_r  <= X_W'(DEF_X1);
            act_y1_r  <= Y_W'(DEF_Y1);
            act_x2_r  <= X_W'(DEF_X2);
            act_y2_r  <= Y_W'(DEF_Y2);
            act_col_r <= COLOR_W'(DEF_COLOR);
        end else if (commit) begin
            act_en_r  <= sh_en_r;
            act_x1_r  <= sh_x1_r;
            act_y1_r  <= sh_y1_r;
            act_x2_r  <= sh_x2_r;
            act_y2_r  <= sh_y2_r;
            act_col_r <= sh_col_r;
        end else begin
            act_en_r  <= act_en_r;
            act_x1_r  <= act_x1_r;
            act_y1_r  <= act_y1_r;
            act_x2_r  <= act_x2_r;
            act_y2_r  <= act_y2_r;
            act_col_r <= act_col_r;
        end
    end

    assign en    = act_en_r;
    assign x1    = act_x1_r;
    assign y1    = act_y1_r;
    assign x2    = act_x2_r;
    assign y2    = act_y2_r;
    assign color = act_col_r;

endmodule

// File: rtl/sprite_reg_bank.sv
// sprite_reg_bank
//   Double-buffered register bank for NUM_SPRITES sprites. Host writes go to
//   shadow registers; a frame_start pulse or a commit command copies every
//   shadow into the active registers in a single cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   write, command,
//   sprite_sel, data           host command port, one command per cycle
//   frame_start                vertical-blank pulse, triggers a commit
//   out_enable, out_x1, out_x2,
//   out_y1, out_y2, out_color  active sprite state, sprite i in slice i
//   pending                    uncommitted shadow writes exist
module sprite_reg_bank
    import sprite_reg_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int COLOR_W     = 3,
    parameter int DATA_W      = 10,
    parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write,
    input  logic [3:0]                     command,
    input  logic [SEL_W-1:0]               sprite_sel,
    input  logic [DATA_W-1:0]              data,
    input  logic                           frame_start,
    output logic [NUM_SPRITES-1:0]         out_enable,
    output logic [NUM_SPRITES*X_W-1:0]     out_x1,
    output logic [NUM_SPRITES*X_W-1:0]     out_x2,
    output logic [NUM_SPRITES*Y_W-1:0]     out_y1,
    output logic [NUM_SPRITES*Y_W-1:0]     out_y2,
    output logic [NUM_SPRITES*COLOR_W-1:0] out_color,
    output logic                           pending
);

    logic commit_s;
    logic sel_ok_s;
    logic accept_s;
    logic pending_r;

    // The commit command ignores sprite_sel, so it is decoded separately.
    assign commit_s = frame_start | (write & (command == CMD_COMMIT));
    assign sel_ok_s = (32'(sprite_sel) < 32'(NUM_SPRITES));
    assign accept_s = write & sel_ok_s & is_write_cmd(command);

    // Pending flag: a same-cycle write wins over a commit so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (accept_s) begin
            pending_r <= 1'b1;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    assign pending = pending_r;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
        logic slot_wr_s;

        assign slot_wr_s = accept_s & (sprite_sel == SEL_W'(i));

        sprite_slot #(
            .X_W        (X_W),
            .Y_W        (Y_W),
            .COLOR_W    (COLOR_W),
            .DATA_W     (DATA_W),
            .DEFAULT_EN ((i == 0) ? 1'b1 : 1'b0)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (slot_wr_s),
            .cmd    (command),
            .data   (data),
            .commit (commit_s),
            .en     (out_enable[i]),
            .x1     (out_x1[i*X_W +: X_W]),
            .y1     (out_y1[i*Y_W +: Y_W]),
            .x2     (out_x2[i*X_W +: X_W]),
            .y2     (out_y2[i*Y_W +: Y_W]),
            .color  (out_color[i*COLOR_W +: COLOR_W])
        );
    end

endmodule

// File: tb/tb_sprite_reg_bank.sv
// tb_sprite_reg_bank
//   Directed and randomized stimulus for sprite_reg_bank, checked against a
//   behavioural shadow/active model held in plain integer arrays.
module tb_sprite_reg_bank;

    localparam int NS = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 3;
    localparam int DW = 10;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              write;
    logic [3:0]        command;
    logic [SW-1:0]     sprite_sel;
    logic [DW-1:0]     data;
    logic              frame_start;
    logic [NS-1:0]     out_enable;
    logic [NS*XW-1:0]  out_x1;
    logic [NS*XW-1:0]  out_x2;
    logic [NS*YW-1:0]  out_y1;
    logic [NS*YW-1:0]  out_y2;
    logic [NS*CW-1:0]  out_color;
    logic              pending;

    sprite_reg_bank #(
        .NUM_SPRITES (NS),
        .X_W         (XW),
        .Y_W         (YW),
        .COLOR_W     (CW),
        .DATA_W      (DW),
        .SEL_W       (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .command     (command),
        .sprite_sel  (sprite_sel),
        .data        (data),
        .frame_start (frame_start),
        .out_enable  (out_enable),
        .out_x1      (out_x1),
        .out_x2      (out_x2),
        .out_y1      (out_y1),
        .out_y2      (out_y2),
        .out_color   (out_color),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: shadow and active state per sprite.
    int sh_en[NS], sh_x1[NS], sh_y1[NS], sh_x2[NS], sh_y2[NS], sh_col[NS];
    int ac_en[NS], ac_x1[NS], ac_y1[NS], ac_x2[NS], ac_y2[NS], ac_col[NS];
    int m_pending;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp)) begin
            n_pass++;
        end else begin
            $error("FAIL %s[%0d]: got %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            sh_en[i] = (i == 0) ? 1 : 0;
            sh_x1[i] = 0;  sh_y1[i] = 0;
            sh_x2[i] = 100; sh_y2[i] = 100;
            sh_col[i] = 7;
            ac_en[i] = sh_en[i]; ac_x1[i] = 0; ac_y1[i] = 0;
            ac_x2[i] = 100; ac_y2[i] = 100; ac_col[i] = 7;
        end
        m_pending = 0;
    endtask

    task automatic model_step(input int wr, input int cmd, input int sel, input int d, input int fs);
        bit commit, accepted;
        int w;
        commit   = (fs != 0) || (wr != 0 && cmd == 9);
        accepted = (wr != 0) && (sel < NS) && (cmd >= 1) && (cmd <= 8);
        // Commit sees the shadow as it stood before this cycle's write.
        if (commit) begin
            for (int i = 0; i < NS; i++) begin
                ac_en[i] = sh_en[i]; ac_x1[i] = sh_x1[i]; ac_y1[i] = sh_y1[i];
                ac_x2[i] = sh_x2[i]; ac_y2[i] = sh_y2[i]; ac_col[i] = sh_col[i];
            end
            m_pending = 0;
        end
        if (accepted) begin
            case (cmd)
                1: sh_en[sel]  = d % 2;
                2: sh_x1[sel]  = d % 1024;
                3: sh_y1[sel]  = d % 512;
                4: sh_x2[sel]  = d % 1024;
                5: sh_y2[sel]  = d % 512;
                6: sh_col[sel] = d % 8;
                7: begin
                    w = (sh_x2[sel] - sh_x1[sel] + 1024) % 1024;
                    sh_x1[sel] = d % 1024;
                    sh_x2[sel] = (d + w) % 1024;
                end
                8: begin
                    w = (sh_y2[sel] - sh_y1[sel] + 512) % 512;
                    sh_y1[sel] = d % 512;
                    sh_y2[sel] = (d + w) % 512;
                end
                default: ;
            endcase
            m_pending = 1;
        end
    endtask

    // One clock: drive, let the edge happen, update model, release strobes.
    task automatic cycle(input int wr, input int cmd, input int sel, input int d, input int fs);
        write       = (wr != 0);
        command     = 4'(cmd);
        sprite_sel  = SW'(sel);
        data        = DW'(d);
        frame_start = (fs != 0);
        @(posedge clk);
        model_step(wr, cmd, sel, d, fs);
        #1;
        write       = 1'b0;
        command     = 4'd0;
        frame_start = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NS; i++) begin
            check({tag, ".en"},  i, 32'(out_enable[i]),           ac_en[i]);
            check({tag, ".x1"},  i, 32'(out_x1[i*XW +: XW]),      ac_x1[i]);
            check({tag, ".y1"},  i, 32'(out_y1[i*YW +: YW]),      ac_y1[i]);
            check({tag, ".x2"},  i, 32'(out_x2[i*XW +: XW]),      ac_x2[i]);
            check({tag, ".y2"},  i, 32'(out_y2[i*YW +: YW]),      ac_y2[i]);
            check({tag, ".col"}, i, 32'(out_color[i*CW +: CW]),   ac_col[i]);
        end
        check({tag, ".pending"}, 0, 32'(pending), m_pending);
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; command = 4'd0; sprite_sel = '0;
        data = '0; frame_start = 1'b0;
        model_reset();
        #12;
        check("rst_en0", 0, 32'(out_enable[0]), 1);
        check("rst_en1", 1, 32'(out_enable[1]), 0);
        check("rst_x2_0", 0, 32'(out_x2[0 +: XW]), 100);
        check("rst_col0", 0, 32'(out_color[0 +: CW]), 7);
        check_all("reset");
        reset = 1'b0;

        // Shadow write is invisible until the frame boundary.
        cycle(1, 2, 1, 40, 0);
        check("x1_hold", 1, 32'(out_x1[1*XW +: XW]), 0);
        check("pend_set", 0, 32'(pending), 1);
        cycle(0, 0, 0, 0, 1);
        check("x1_commit", 1, 32'(out_x1[1*XW +: XW]), 40);
        check("pend_clr", 0, 32'(pending), 0);
        check_all("frame");

        // Move-x wraps modulo 1024.
        cycle(1, 2, 2, 10, 0);
        cycle(1, 4, 2, 60, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 7, 2, 1000, 0);
        cycle(0, 0, 0, 0, 1);
        check("move_x1", 2, 32'(out_x1[2*XW +: XW]), 1000);
        check("move_x2", 2, 32'(out_x2[2*XW +: XW]), 26);
        check_all("move");

        // Write in the same cycle as frame_start lands only in the shadow.
        cycle(1, 6, 0, 3, 1);
        check("col_same", 0, 32'(out_color[0 +: CW]), 7);
        check("pend_same", 0, 32'(pending), 1);
        cycle(0, 0, 0, 0, 1);
        check("col_next", 0, 32'(out_color[0 +: CW]), 3);
        check_all("same_cycle");

        // Out-of-range select and unused command codes are ignored.
        cycle(1, 4, 5, 555, 0);
        check("oor_pend", 0, 32'(pending), 0);
        cycle(1, 12, 1, 77, 0);
        check("badcmd_pend", 0, 32'(pending), 0);
        cycle(0, 0, 0, 0, 1);
        check_all("ignored");

        // Commit command alone, with an out-of-range select.
        cycle(1, 3, 3, 200, 0);
        check("y1_hold", 3, 32'(out_y1[3*YW +: YW]), 0);
        cycle(1, 9, 7, 0, 0);
        check("cmd9_y1", 3, 32'(out_y1[3*YW +: YW]), 200);
        check("cmd9_pend", 0, 32'(pending), 0);

        // Asynchronous reset mid-frame with pending high.
        cycle(1, 1, 2, 1, 0);
        check("pre_rst_pend", 0, 32'(pending), 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_pend", 0, 32'(pending), 0);
        check("arst_x1_1", 1, 32'(out_x1[1*XW +: XW]), 0);
        check("arst_col0", 0, 32'(out_color[0 +: CW]), 7);
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int wr, cmd, sel, d, fs;
            wr  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            cmd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(1, 8));
            sel = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 1023));
            fs  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            cycle(wr, cmd, sel, d, fs);
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
